// File: rtl/phy_frame_reader_pkg.sv
// ---------------------------------------------------------------------------
// phy_frame_reader_pkg
// Shared definitions for the capture-buffer read side: the number of virtual
// channels, header word field layout, FSM state encoding, the skid FIFO entry
// format and two small helpers (header word build, next non-empty channel).
// ---------------------------------------------------------------------------
package phy_frame_reader_pkg;

   localparam int NUM_VCHN     = 4;
   localparam int VCHN_W       = 2;
   localparam int CNT_W        = 8;
   localparam int DATA_W       = 32;

   // Header word: {6'd0, vchn[1:0], 16'd0, count[7:0]}
   localparam int HDR_VCHN_LSB = 24;
   localparam int HDR_CNT_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_DRAIN
   } state_e;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } fifo_ent_t;

   function automatic logic [DATA_W-1:0] hdr_word(input logic [VCHN_W-1:0] k,
                                                  input logic [CNT_W-1:0]  cnt);
      logic [DATA_W-1:0] w;
      w = '0;
      w[HDR_VCHN_LSB +: VCHN_W] = k;
      w[HDR_CNT_LSB  +: CNT_W]  = cnt;
      return w;
   endfunction

   // Lowest channel index >= start whose non-empty flag is set.
   // Returns {found, index}.
   function automatic logic [VCHN_W:0] first_nz(input logic [NUM_VCHN-1:0] nz,
                                                 input logic [VCHN_W:0]     start);
      logic [VCHN_W:0] r;
      r = '0;
      for (int j = NUM_VCHN-1; j >= 0; j--) begin
         if (nz[j] && (j >= int'(start))) r = {1'b1, VCHN_W'(j)};
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_skid_fifo.sv
// ---------------------------------------------------------------------------
// frame_skid_fifo
// Small synchronous FIFO holding {sop, eop, data} stream entries in front of
// the valid/ready output. Storage is reset so the output word reads 0 while
// empty after reset.
//   clk, rst_n   : clock, async active-low reset
//   i_push/i_din : write strobe and entry (ignored when full)
//   i_pop        : read strobe (ignored when empty)
//   o_dout       : head entry, stable until popped
//   o_empty/o_full/o_count : occupancy
// ---------------------------------------------------------------------------
module frame_skid_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 34
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_din,
   input  logic                     i_pop,
   output logic [W-1:0]             o_dout,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          push_ok, pop_ok;

   assign push_ok = i_push & (cnt_q != FULL_CNT);
   assign pop_ok  = i_pop  & (cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= i_din;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_ok) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   assign o_dout  = mem_q[rd_q];
   assign o_empty = (cnt_q == '0);
   assign o_full  = (cnt_q == FULL_CNT);
   assign o_count = cnt_q;

endmodule

// File: rtl/phy_frame_reader.sv
// ---------------------------------------------------------------------------
// phy_frame_reader
// Walks the four virtual channels of the frozen capture half after each
// completed acquisition and serialises them as one framed 32-bit stream:
// four header words (one per channel, carrying its word count) followed by
// every non-empty channel's payload in channel order.
//   i_frame_ready          : level, a rising edge in IDLE starts a frame
//   i_out_size             : expected frame length, latched at start
//   i_data_count/o_rd_vchn : per-channel count mux
//   o_rd_vchn/o_rd_addr/i_rd_data : RAM read port, data RD_LAT cycles later
//   o_data/o_valid/i_ready/o_sop/o_eop : framed output stream
//   o_busy     : frame in progress
//   o_overrun  : pulse, new frame_ready edge while busy (frame not restarted)
//   o_size_err : pulse after EOP accept when emitted words != i_out_size
// ---------------------------------------------------------------------------
module phy_frame_reader
   import phy_frame_reader_pkg::*;
#(
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_frame_ready,
   input  logic [15:0] i_out_size,
   input  logic [7:0]  i_data_count,
   output logic [1:0]  o_rd_vchn,
   output logic [7:0]  o_rd_addr,
   input  logic [31:0] i_rd_data,
   output logic [31:0] o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_sop,
   output logic        o_eop,
   output logic        o_busy,
   output logic        o_overrun,
   output logic        o_size_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e                              state_q, state_d;
   logic [VCHN_W-1:0]                   vchn_q, vchn_d;
   logic [CNT_W-1:0]                    addr_q, addr_d;
   logic [NUM_VCHN-1:0][CNT_W-1:0]      cnt_q, cnt_d;
   logic [15:0]                         size_q, emit_q;
   logic [RD_LAT-1:0]                   vld_pipe_q, last_pipe_q;
   logic                                fr_q, overrun_q, size_err_q;

   logic                                rise, issue, issue_last, hdr_push, hdr_eop;
   logic                                fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [CW-1:0]                       fifo_cnt;
   fifo_ent_t                           fifo_din, fifo_dout;
   logic [7:0]                          inflight, occ;
   logic                                can_issue;
   logic [NUM_VCHN-1:0]                 nz;
   logic [VCHN_W:0]                     nxt;

   // fr_q resets high so a level already asserted at reset release is not
   // mistaken for a fresh completion.
   assign rise = i_frame_ready & ~fr_q;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(vld_pipe_q[i]);
   end

   // Reserve FIFO room for every read still in the RAM pipe so returned data
   // always has a slot.
   assign occ       = 8'(fifo_cnt) + inflight;
   assign can_issue = (occ < 8'(FIFO_DEPTH));

   always_comb begin
      for (int k = 0; k < NUM_VCHN; k++) nz[k] = (cnt_q[k] != '0);
   end

   always_comb begin
      state_d    = state_q;
      vchn_d     = vchn_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      hdr_push   = 1'b0;
      hdr_eop    = 1'b0;
      nxt        = '0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_HDR;
               vchn_d  = '0;
               addr_d  = '0;
            end
         end
         ST_HDR: begin
            if (!fifo_full) begin
               hdr_push      = 1'b1;
               cnt_d[vchn_q] = i_data_count;
               if (vchn_q == VCHN_W'(NUM_VCHN-1)) begin
                  // cnt_q[3] is not latched yet, use the live count.
                  nxt = first_nz({i_data_count != '0, nz[NUM_VCHN-2:0]}, '0);
                  addr_d = '0;
                  if (nxt[VCHN_W]) begin
                     state_d = ST_DATA;
                     vchn_d  = nxt[VCHN_W-1:0];
                  end else begin
                     state_d = ST_DRAIN;
                     hdr_eop = 1'b1;
                  end
               end else begin
                  vchn_d = vchn_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (can_issue) begin
               issue = 1'b1;
               if (addr_q == cnt_q[vchn_q] - 1'b1) begin
                  nxt    = first_nz(nz, {1'b0, vchn_q} + 1'b1);
                  addr_d = '0;
                  if (nxt[VCHN_W]) begin
                     vchn_d = nxt[VCHN_W-1:0];
                  end else begin
                     state_d    = ST_DRAIN;
                     issue_last = 1'b1;
                  end
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (inflight == '0 && fifo_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_push = hdr_push | vld_pipe_q[RD_LAT-1];
      if (hdr_push) begin
         fifo_din.sop  = (vchn_q == '0);
         fifo_din.eop  = hdr_eop;
         fifo_din.data = hdr_word(vchn_q, i_data_count);
      end else begin
         fifo_din.sop  = 1'b0;
         fifo_din.eop  = last_pipe_q[RD_LAT-1];
         fifo_din.data = i_rd_data;
      end
   end

   assign fifo_pop = i_ready & ~fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         vchn_q      <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         size_q      <= '0;
         emit_q      <= '0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         fr_q        <= 1'b1;
         overrun_q   <= 1'b0;
         size_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         vchn_q    <= vchn_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         fr_q      <= i_frame_ready;
         overrun_q <= rise & (state_q != ST_IDLE);
         if (state_q == ST_IDLE && rise) begin
            size_q <= i_out_size;
            emit_q <= '0;
         end else if (fifo_pop) begin
            emit_q <= emit_q + 1'b1;
         end
         size_err_q <= fifo_pop & fifo_dout.eop & ((emit_q + 1'b1) != size_q);
         vld_pipe_q[0]  <= issue;
         last_pipe_q[0] <= issue_last;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            last_pipe_q[i] <= last_pipe_q[i-1];
         end
      end
   end

   frame_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(fifo_ent_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (fifo_push),
      .i_din   (fifo_din),
      .i_pop   (fifo_pop),
      .o_dout  (fifo_dout),
      .o_empty (fifo_empty),
      .o_full  (fifo_full),
      .o_count (fifo_cnt)
   );

   assign o_valid    = ~fifo_empty;
   assign o_data     = fifo_dout.data;
   assign o_sop      = o_valid & fifo_dout.sop;
   assign o_eop      = o_valid & fifo_dout.eop;
   assign o_busy     = (state_q != ST_IDLE);
   assign o_rd_vchn  = vchn_q;
   assign o_rd_addr  = addr_q;
   assign o_overrun  = overrun_q;
   assign o_size_err = size_err_q;

endmodule

// File: tb/tb_phy_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_phy_frame_reader
// Directed vector table of channel counts / out_size / sink behaviour with
// hand-computed word totals, plus hand sequences for reset, overrun and
// reset-during-frame. A two-cycle registered RAM model returns a word that
// encodes {channel, address} so order, loss and duplication are all visible.
// ---------------------------------------------------------------------------
module tb_phy_frame_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_frame_ready = 1'b0;
   logic [15:0] i_out_size = '0;
   logic [7:0]  i_data_count;
   logic [1:0]  o_rd_vchn;
   logic [7:0]  o_rd_addr;
   logic [31:0] i_rd_data = '0;
   logic [31:0] o_data;
   logic        o_valid, o_sop, o_eop, o_busy, o_overrun, o_size_err;
   logic        i_ready = 1'b0;

   logic [7:0]  tb_cnt [4];
   int          rdy_mode = 0;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   phy_frame_reader #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_frame_ready (i_frame_ready),
      .i_out_size    (i_out_size),
      .i_data_count  (i_data_count),
      .o_rd_vchn     (o_rd_vchn),
      .o_rd_addr     (o_rd_addr),
      .i_rd_data     (i_rd_data),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_sop         (o_sop),
      .o_eop         (o_eop),
      .o_busy        (o_busy),
      .o_overrun     (o_overrun),
      .o_size_err    (o_size_err)
   );

   assign i_data_count = tb_cnt[o_rd_vchn];

   // RAM: registered address, registered output.
   logic [1:0] ra_ch;
   logic [7:0] ra_a;
   always @(posedge clk) begin
      ra_ch     <= o_rd_vchn;
      ra_a      <= o_rd_addr;
      i_rd_data <= {8'hD0, 6'd0, ra_ch, 8'd0, ra_a};
   end

   // Sink readiness: always ready, or ready about one cycle in three.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         i_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      end
   end

   // Monitor
   logic [33:0] got [$];
   int n_serr = 0;
   int n_ovr  = 0;
   int n_busy = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid && i_ready) got.push_back({o_sop, o_eop, o_data});
         if (o_size_err) n_serr++;
         if (o_overrun)  n_ovr++;
         if (o_busy)     n_busy++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   typedef struct {
      int c [4];
      int size;
      int mode;
      int exp_words;
      int exp_serr;
      int exp_ovr;
      bit glitch;
   } vec_t;

   vec_t tbl [7];

   task automatic run_vec(input vec_t v, input string tag);
      int base, ovr0, serr0, busy0, k, sum;
      logic [33:0] exp_q [$];
      for (int i = 0; i < 4; i++) tb_cnt[i] = 8'(v.c[i]);
      i_out_size = 16'(v.size);
      rdy_mode   = v.mode;
      i_frame_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      base  = got.size();
      ovr0  = n_ovr;
      serr0 = n_serr;
      i_frame_ready = 1'b1;
      k = 0;
      while (!o_busy && k < 10) begin @(posedge clk); #1; k++; end
      chk({tag, " start"}, 64'(o_busy), 64'd1);
      if (v.glitch) begin
         repeat (5) @(posedge clk);
         #1 i_frame_ready = 1'b0;
         @(posedge clk);
         #1 i_frame_ready = 1'b1;
      end
      k = 0;
      while (o_busy && k < 20000) begin @(posedge clk); #1; k++; end
      chk({tag, " done"}, 64'(o_busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      // Expected stream
      sum = 0;
      for (int ch = 0; ch < 4; ch++) begin
         exp_q.push_back({(ch == 0), 1'b0, 6'd0, 2'(ch), 16'd0, 8'(v.c[ch])});
         sum += v.c[ch];
      end
      for (int ch = 0; ch < 4; ch++)
         for (int a = 0; a < v.c[ch]; a++)
            exp_q.push_back({2'b00, 8'hD0, 6'd0, 2'(ch), 8'd0, 8'(a)});
      exp_q[exp_q.size()-1][32] = 1'b1;
      chk({tag, " model_len"}, 64'(exp_q.size()), 64'(v.exp_words));
      chk({tag, " words"}, 64'(got.size() - base), 64'(v.exp_words));
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < got.size())
            chk($sformatf("%s word%0d", tag, i), 64'(got[base+i]), 64'(exp_q[i]));
      chk({tag, " size_err"}, 64'(n_serr - serr0), 64'(v.exp_serr));
      chk({tag, " overrun"}, 64'(n_ovr - ovr0), 64'(v.exp_ovr));
      // Level still high after the frame: no restart.
      busy0 = n_busy;
      repeat (10) @(posedge clk);
      #1;
      chk({tag, " no_restart"}, 64'(n_busy - busy0), 64'd0);
      i_frame_ready = 1'b0;
      rdy_mode = 0;
   endtask

   initial begin
      int busy0, k;
      //              counts                size mode words serr ovr glitch
      tbl[0] = '{'{3, 0, 5, 1},             13,  0,   13,   0,   0,  1'b0};
      tbl[1] = '{'{0, 0, 0, 0},              4,  0,    4,   0,   0,  1'b0};
      tbl[2] = '{'{255, 255, 255, 255},   1024,  1, 1024,   0,   0,  1'b0};
      tbl[3] = '{'{4, 4, 0, 4},             20,  0,   16,   1,   0,  1'b0};
      tbl[4] = '{'{10, 10, 10, 10},         44,  0,   44,   0,   1,  1'b1};
      tbl[5] = '{'{0, 0, 2, 0},              6,  1,    6,   0,   0,  1'b0};
      tbl[6] = '{'{1, 2, 0, 0},              7,  1,    7,   0,   0,  1'b0};
      for (int i = 0; i < 4; i++) tb_cnt[i] = 8'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {o_valid, o_sop, o_eop, o_busy, o_overrun, o_size_err,
                            o_rd_vchn, o_rd_addr, o_data}, 64'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_reset", {o_busy, o_valid}, 64'd0);

      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("v%0d", i));

      // Reset in the middle of DATA with frame_ready held high.
      for (int i = 0; i < 4; i++) tb_cnt[i] = 8'd255;
      i_out_size = 16'd1024;
      repeat (2) @(posedge clk);
      #1 i_frame_ready = 1'b1;
      k = 0;
      while (!o_busy && k < 10) begin @(posedge clk); #1; k++; end
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_async", {o_valid, o_sop, o_eop, o_busy, o_overrun, o_size_err,
                            o_rd_vchn, o_rd_addr, o_data}, 64'd0);
      @(posedge clk);
      #1;
      chk("rst_mid_edge", {o_valid, o_busy, o_rd_vchn, o_rd_addr}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      busy0 = n_busy;
      repeat (20) @(posedge clk);
      #1;
      chk("rst_no_start", 64'(n_busy - busy0), 64'd0);
      run_vec(tbl[6], "v6_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
